xor_share_arb: RTL
==================

Name: xor_share_arb

Overview:
- Shares one 4-bit XOR datapath (s = a ^ b) between NREQ requesters using round-robin arbitration.
- Accepts at most one operand pair per cycle and registers the result with the winning requester's ID.
- Presents the result on a single valid/ready output channel.
- Sits between the lab's operand sources and its result sink; the XOR cell is instantiated exactly once inside.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  requester i has an operand pair.
- req_a  input  NREQ x 4  operand a per requester (unpacked array [NREQ][4]).
- req_b  input  NREQ x 4  operand b per requester.
- req_ready  output  NREQ  one-hot grant; the pair is accepted when req_valid[i] && req_ready[i].
- res_valid  output  1  result register holds data.
- res_data  output  4  registered req_a[g] ^ req_b[g].
- res_id  output  IDW  index g of the requester that produced res_data.
- res_ready  input  1  sink accepts the result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst). While rst=1, all of the following hold immediately, independent of clk:
  - res_valid=0, res_data=0, res_id=0.
  - rr_ptr=0.
  - req_ready=0.
- A reset mid-operation discards the held result and any pending grant.
- Output register has two states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- can_load = EMPTY || (FULL && res_ready).
- Grant (combinational):
  - If can_load and any req_valid is set, req_ready is one-hot at the first asserted req_valid[i], searching from index rr_ptr upward and wrapping modulo NREQ.
  - Otherwise req_ready=0.
  - req_ready never asserts for a requester whose req_valid=0.
- Accept edge:
  - res_data <= req_a[g]^req_b[g], res_id <= g, state -> FULL.
  - rr_ptr <= (g+1) mod NREQ; the wrap goes from NREQ-1 to 0.
  - Latency is 1 cycle from accept to res_valid.
- Drain without new accept: if FULL && res_ready and no req_valid is set, state -> EMPTY and res_data/res_id hold their last values.
- Simultaneous drain and accept: the register is overwritten in the same edge and res_valid stays 1. Throughput is one op per cycle under continuous res_ready.
- Backpressure: if FULL && !res_ready, then:
  - req_ready=0;
  - res_data and res_id are stable;
  - rr_ptr holds.
- No requests: rr_ptr holds; it does not advance on idle cycles.
- Fairness: a continuously requesting requester is granted within NREQ accepts.
- Requester-side rule: a requester must hold req_a/req_b stable while req_valid=1 && req_ready=0. The block does not check this.

Optional Feature:
- Macro: XOR_SHARE_ARB_STATS_EN.
- When defined:
  - Extra output port stat_ops (16 bits) counts accepted operations and saturates at 16'hFFFF.
  - Extra output port stat_stall (16 bits) counts cycles with FULL && !res_ready && |req_valid, saturating.
  - Both counters reset to 0 on rst.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package xor_share_pkg:
  - NIB_W=4;
  - typedef logic [NIB_W-1:0] nib_t;
  - typedef enum logic {EMPTY, FULL} ostate_t;
  - STAT_W=16.
- One sub-module, xor_share_rr_pick:
  - parameter NREQ;
  - inputs: req vector, rr_ptr;
  - outputs: one-hot gnt, index g, any;
  - purely combinational, testable on its own.
- The XOR cell is instantiated once at the top level on the muxed operands.

Test Plan:
- Reset: assert rst mid-cycle with res_valid=1 -> res_valid, req_ready and rr_ptr go to 0 immediately; after release with no requests, outputs stay 0.
- Single requester: req_valid=4'b0100, a=4'hA, b=4'h5, res_ready=1 -> req_ready=4'b0100 for one cycle; next cycle res_valid=1, res_data=4'hF, res_id=2.
- Round-robin: all four req_valid=1 for 8 cycles with res_ready=1 -> grant order 0,1,2,3,0,1,2,3; res_id follows one cycle later; back-to-back res_valid=1.
- Backpressure: FULL with res_ready=0 for 3 cycles, req_valid=4'b1111 -> req_ready=0, res_data/res_id stable, rr_ptr unchanged; the cycle res_ready=1, the next grant is issued and the register is overwritten with no bubble.
- Wrap and skip: rr_ptr=3, req_valid=4'b0010 -> grant index 1, and rr_ptr becomes 2.
- STATS_EN build: 70000 accepts -> stat_ops=16'hFFFF (saturated); 5 backpressured cycles with pending requests -> stat_stall=5.

Source files
------------

// File: rtl/xor_share_pkg.sv
// Shared types and constants for the round-robin XOR sharing block.
// The XOR cell lives here as a function so the top instantiates it exactly once.
package xor_share_pkg;
    localparam int NIB_W  = 4;
    localparam int STAT_W = 16;

    typedef logic [NIB_W-1:0] nib_t;
    typedef enum logic {EMPTY, FULL} ostate_t;

    function automatic nib_t xor_nib(input nib_t a, input nib_t b);
        return a ^ b;
    endfunction
endpackage

// File: rtl/xor_share_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// wrapping modulo NREQ; reports one-hot gnt, its index g and whether any won.
module xor_share_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  g,
    output logic            any
);
    int d;
    int best_d;

    // Pick the requester with the smallest forward distance from rr_ptr.
    always_comb begin
        g      = '0;
        any    = 1'b0;
        d      = 0;
        best_d = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(rr_ptr)) % NREQ;
            if (req[i] && d < best_d) begin
                best_d = d;
                g      = IDW'(i);
                any    = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++)
            gnt[i] = any && (g == IDW'(i));
    end
endmodule

// File: rtl/xor_share_arb.sv
// NREQ requesters share one 4-bit XOR via round-robin; result is registered with its ID.
// Optional XOR_SHARE_ARB_STATS_EN adds saturating stat_ops / stat_stall counters.
module xor_share_arb
    import xor_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  nib_t              req_a [NREQ],
    input  nib_t              req_b [NREQ],
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output nib_t              res_data,
    output logic [IDW-1:0]    res_id,
`ifdef XOR_SHARE_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_stall,
`endif
    input  logic              res_ready
);
    ostate_t         state, state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  g;
    logic            any;
    logic            can_load;
    logic            accept;
    nib_t            op_a, op_b, xr;

    xor_share_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (gnt),
        .g      (g),
        .any    (any)
    );

    // rst gating keeps req_ready low during reset even though EMPTY allows loading.
    assign can_load  = (state == EMPTY) || res_ready;
    assign accept    = can_load && any && !rst;
    assign req_ready = accept ? gnt : '0;
    assign res_valid = (state == FULL);

    assign op_a = req_a[g];
    assign op_b = req_b[g];
    assign xr   = xor_nib(op_a, op_b);

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (accept) state_nx = FULL;
            FULL:    if (accept) state_nx = FULL;
                     else if (res_ready) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    // Data/ID hold their last values on a plain drain; only an accept rewrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_id   <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            res_data <= xr;
            res_id   <= g;
            rr_ptr   <= (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
        end
    end

`ifdef XOR_SHARE_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (accept && stat_ops != '1)
                stat_ops <= stat_ops + 1'b1;
            if (state == FULL && !res_ready && |req_valid && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule
